// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot blocks: slot count, debounce defaults,
// the slot vector type and a popcount helper.
package parking_pkg;

  localparam int   N_SLOTS           = 6;
  localparam int   DEFAULT_DB_BITS   = 20;
  localparam logic DEFAULT_OCC_LEVEL = 1'b1;
  localparam int   COUNT_W           = $clog2(N_SLOTS + 1);

  typedef logic [N_SLOTS-1:0] slot_vec_t;

  function automatic logic [COUNT_W-1:0] popcount(input slot_vec_t v);
    logic [COUNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      c = c + COUNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_slot_sensor_filter_slot_debounce.sv
// One sensor line: two-flop synchroniser, then a level is accepted only after it
// has differed from the accepted level for 2^DB_BITS consecutive cycles.
module slot_debounce #(
  parameter int   DB_BITS   = 20,
  parameter logic OCC_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic flip
);

  logic               r_sync1;
  logic               r_sync2;
  logic [DB_BITS-1:0] r_cnt;
  logic               r_level;

  logic w_target;
  logic w_cnt_max;
  logic w_flip;

  // level is "slot free", so the target is the inverse of "car present"
  assign w_target  = (r_sync2 != OCC_LEVEL);
  assign w_cnt_max = &r_cnt;
  assign w_flip    = (w_target != r_level) && w_cnt_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= ~OCC_LEVEL;
      r_sync2 <= ~OCC_LEVEL;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (w_target == r_level) begin
        r_cnt <= '0;
      end else if (w_cnt_max) begin
        r_level <= w_target;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DB_BITS'(1);
      end
    end
  end

  assign level = r_level;
  assign flip  = w_flip;

endmodule

// File: rtl/parking_slot_sensor_filter.sv
// Debounces every slot sensor independently and derives the free-slot count,
// lot-full flag and a registered change strobe with the mask of flipped slots.
module parking_slot_sensor_filter
  import parking_pkg::*;
#(
  parameter int   DB_BITS   = DEFAULT_DB_BITS,
  parameter logic OCC_LEVEL = DEFAULT_OCC_LEVEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SLOTS-1:0] sensor_raw,
  output logic [N_SLOTS-1:0] slot_free,
  output logic [COUNT_W-1:0] free_count,
  output logic               lot_full,
  output logic               slot_changed,
  output logic [N_SLOTS-1:0] changed_mask
);

  slot_vec_t w_level;
  slot_vec_t w_flip;
  logic      r_slot_changed;
  slot_vec_t r_changed_mask;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    slot_debounce #(
      .DB_BITS  (DB_BITS),
      .OCC_LEVEL(OCC_LEVEL)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (sensor_raw[g]),
      .level(w_level[g]),
      .flip (w_flip[g])
    );
  end

  // A flip request is exactly new XOR old on the edge it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_changed <= 1'b0;
      r_changed_mask <= '0;
    end else begin
      r_slot_changed <= |w_flip;
      r_changed_mask <= w_flip;
    end
  end

  assign slot_free    = w_level;
  assign free_count   = popcount(w_level);
  assign lot_full     = (free_count == '0);
  assign slot_changed = r_slot_changed;
  assign changed_mask = r_changed_mask;

endmodule

// File: tb/tb_parking_slot_sensor_filter.sv
// Bench for parking_slot_sensor_filter with DB_BITS=4: table vectors, directed
// multi-cycle sequences and random traffic against a sliding-window reference.
module tb_parking_slot_sensor_filter;
  import parking_pkg::*;

  localparam int        DB       = 4;
  localparam int        WIN      = 1 << DB;
  localparam logic      OCC      = 1'b1;
  localparam slot_vec_t FREE_RAW = {N_SLOTS{~OCC}};
  localparam int        EW       = 2 * N_SLOTS + 1;

  logic               clk;
  logic               rst;
  slot_vec_t          sensor_raw;
  slot_vec_t          slot_free;
  logic [COUNT_W-1:0] free_count;
  logic               lot_full;
  logic               slot_changed;
  slot_vec_t          changed_mask;

  int n_checks;
  int n_errors;
  int n_pulses;

  // reference state: accepted levels plus raw and synchronised sample history
  slot_vec_t     m_free;
  slot_vec_t     raw_q[$];
  slot_vec_t     s_q[$];
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic      rst;
    slot_vec_t raw;
    int        hold;
    slot_vec_t exp_free;
    int        exp_cnt;
    logic      exp_chg;
    slot_vec_t exp_mask;
  } vec_t;

  vec_t vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  parking_slot_sensor_filter #(
    .DB_BITS  (DB),
    .OCC_LEVEL(OCC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .slot_free   (slot_free),
    .free_count  (free_count),
    .lot_full    (lot_full),
    .slot_changed(slot_changed),
    .changed_mask(changed_mask)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A slot flips once its last WIN synchronised samples all disagree with the
  // accepted level; samples reach the debouncer two edges after capture.
  task automatic model_edge(input logic r, input slot_vec_t raw);
    slot_vec_t nf;
    slot_vec_t s;
    logic      all_diff;
    if (r) begin
      m_free = '1;
      raw_q.delete();
      raw_q.push_back(FREE_RAW);
      raw_q.push_back(FREE_RAW);
      s_q.delete();
      exp_q.push_back({{N_SLOTS{1'b1}}, 1'b0, {N_SLOTS{1'b0}}});
    end else begin
      s = raw_q[raw_q.size() - 2];
      raw_q.push_back(raw);
      if (raw_q.size() > 4) void'(raw_q.pop_front());
      s_q.push_back(s);
      if (s_q.size() > WIN) void'(s_q.pop_front());
      nf = m_free;
      if (s_q.size() == WIN) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < WIN; k++) begin
            if ((s_q[k][i] != OCC) == m_free[i]) all_diff = 1'b0;
          end
          if (all_diff) nf[i] = ~m_free[i];
        end
      end
      exp_q.push_back({nf, (nf != m_free), nf ^ m_free});
      m_free = nf;
    end
  endtask

  task automatic step(input logic r, input slot_vec_t raw);
    logic [EW-1:0] e;
    slot_vec_t     ef;
    rst        = r;
    sensor_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    e  = exp_q.pop_front();
    ef = e[2*N_SLOTS -: N_SLOTS];
    chk("slot_free", slot_free, ef);
    chk("slot_changed", slot_changed, e[N_SLOTS]);
    chk("changed_mask", changed_mask, e[N_SLOTS-1:0]);
    chk("free_count", free_count, $countones(ef));
    chk("lot_full", lot_full, (ef == '0));
    if (slot_changed) n_pulses++;
  endtask

  task automatic do_reset();
    repeat (3) step(1'b1, '0);
    n_pulses = 0;
  endtask

  initial begin
    int        glen[3];
    int        flip_k;
    slot_vec_t rv;
    logic      steady;
    n_checks   = 0;
    n_errors   = 0;
    n_pulses   = 0;
    rst        = 1'b1;
    sensor_raw = '0;

    vecs[0]  = '{1'b1, 6'h00,  3, 6'h3F, 6, 1'b0, 6'h00};
    vecs[1]  = '{1'b0, 6'h00, 40, 6'h3F, 6, 1'b0, 6'h00};
    vecs[2]  = '{1'b0, 6'h04, 17, 6'h3F, 6, 1'b0, 6'h00};
    vecs[3]  = '{1'b0, 6'h04,  1, 6'h3B, 5, 1'b1, 6'h04};
    vecs[4]  = '{1'b0, 6'h04,  1, 6'h3B, 5, 1'b0, 6'h00};
    vecs[5]  = '{1'b0, 6'h00, 17, 6'h3B, 5, 1'b0, 6'h00};
    vecs[6]  = '{1'b0, 6'h00,  1, 6'h3F, 6, 1'b1, 6'h04};
    vecs[7]  = '{1'b0, 6'h3F, 17, 6'h3F, 6, 1'b0, 6'h00};
    vecs[8]  = '{1'b0, 6'h3F,  1, 6'h00, 0, 1'b1, 6'h3F};
    vecs[9]  = '{1'b0, 6'h3F,  1, 6'h00, 0, 1'b0, 6'h00};
    vecs[10] = '{1'b0, 6'h37, 17, 6'h00, 0, 1'b0, 6'h00};
    vecs[11] = '{1'b0, 6'h37,  1, 6'h08, 1, 1'b1, 6'h08};

    for (int v = 0; v < 12; v++) begin
      repeat (vecs[v].hold) step(vecs[v].rst, vecs[v].raw);
      chk($sformatf("vec%0d_free", v), slot_free, vecs[v].exp_free);
      chk($sformatf("vec%0d_count", v), free_count, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_full", v), lot_full, (vecs[v].exp_cnt == 0));
      chk($sformatf("vec%0d_chg", v), slot_changed, vecs[v].exp_chg);
      chk($sformatf("vec%0d_mask", v), changed_mask, vecs[v].exp_mask);
    end

    // glitches on slot 1: shorter than the window are rejected
    glen = '{10, 15, 16};
    for (int g = 0; g < 3; g++) begin
      do_reset();
      repeat (glen[g]) step(1'b0, 6'h01);
      repeat (12) step(1'b0, 6'h00);
      chk($sformatf("glitch%0d_pulses", glen[g]), n_pulses, (glen[g] >= WIN) ? 1 : 0);
      chk($sformatf("glitch%0d_free0", glen[g]), slot_free[0], (glen[g] >= WIN) ? 0 : 1);
    end

    // bouncing slot 6, then a steady occupy
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      repeat (3) step(1'b0, (seg % 2 == 0) ? 6'h20 : 6'h00);
    end
    flip_k = -1;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 6'h20);
      if (slot_changed && flip_k < 0) flip_k = k;
    end
    chk("bounce_pulses", n_pulses, 1);
    chk("bounce_flip_edge", flip_k, WIN + 1);
    chk("bounce_free", slot_free, 6'h1F);

    // reset in the middle of a debounce restarts qualification
    do_reset();
    repeat (12) step(1'b0, 6'h02);
    repeat (2) step(1'b1, 6'h02);
    chk("midrst_free", slot_free, 6'h3F);
    n_pulses = 0;
    flip_k   = -1;
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 6'h02);
      if (slot_changed && flip_k < 0) flip_k = k;
    end
    chk("midrst_flip_edge", flip_k, WIN + 2);
    chk("midrst_pulses", n_pulses, 1);

    // random traffic: alternating steady and noisy blocks, rare resets
    do_reset();
    rv = '0;
    for (int blk = 0; blk < 80; blk++) begin
      steady = 1'b0;
      if ($urandom_range(0, 1) == 1) steady = 1'b1;
      if (steady) rv = slot_vec_t'($urandom);
      for (int c = 0; c < 40; c++) begin
        if (!steady && $urandom_range(0, 3) == 0) begin
          rv[$urandom_range(0, N_SLOTS - 1)] ^= 1'b1;
        end
        step(($urandom_range(0, 299) == 0), rv);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
